// File: rtl/fft_common_pkg.sv
// Shared FFT datapath definitions: default sizes, flattened-bus slicing and
// the bit-reverse helper used by the bank loader/unloader and address generators.
package fft_common_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } unloader_state_t;

    // MSB of element idx in a flattened bus of width-bit elements; use with -: width
    function automatic int slice_msb(input int idx, input int width);
        return (idx + 1) * width - 1;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] value, input int nbits);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < nbits) begin
                r[b] = value[nbits - 1 - b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/register_bank_unloader_if.sv
// Complex sample stream with valid/ready handshake, bank index and frame-last marker.
interface register_bank_unloader_if
    import fft_common_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = $clog2(DEFAULT_DEPTH)
);
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_real;
    logic signed [WIDTH-1:0] out_imag;
    logic [IDX_W-1:0]        out_index;
    logic                    out_last;

    modport master (
        output out_valid, out_real, out_imag, out_index, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_real, out_imag, out_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/bitrev_addr.sv
// Combinational index reorder: passes the index through or bit-reverses it over IDX_W bits.
module bitrev_addr
    import fft_common_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx_in,
    input  logic             rev_en,
    output logic [IDX_W-1:0] addr_out
);
    assign addr_out = rev_en ? IDX_W'(bitrev(32'(idx_in), IDX_W)) : idx_in;
endmodule

// File: rtl/register_bank_unloader.sv
// Snapshots a flattened complex register bank on start and streams it out one
// sample per valid/ready transfer, in natural or bit-reversed order.
module register_bank_unloader
    import fft_common_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_WIDTH,
    parameter int  DEPTH = DEFAULT_DEPTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     bitrev_en,
    input  logic [WIDTH*DEPTH-1:0]   data_in_real,
    input  logic [WIDTH*DEPTH-1:0]   data_in_imag,
    register_bank_unloader_if.master out_if,
    output logic                     busy,
    output logic                     done
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic signed [WIDTH-1:0] in_real [DEPTH];
    logic signed [WIDTH-1:0] in_imag [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_unpack
            assign in_real[gi] = data_in_real[slice_msb(gi, WIDTH) -: WIDTH];
            assign in_imag[gi] = data_in_imag[slice_msb(gi, WIDTH) -: WIDTH];
        end
    endgenerate

    unloader_state_t         state_q, state_d;
    logic [IDX_W-1:0]        count_q, count_d;
    logic                    bitrev_q, bitrev_d;
    logic signed [WIDTH-1:0] snap_real_q [DEPTH];
    logic signed [WIDTH-1:0] snap_real_d [DEPTH];
    logic signed [WIDTH-1:0] snap_imag_q [DEPTH];
    logic signed [WIDTH-1:0] snap_imag_d [DEPTH];
    logic                    out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0] out_real_q, out_real_d;
    logic signed [WIDTH-1:0] out_imag_q, out_imag_d;
    logic [IDX_W-1:0]        out_index_q, out_index_d;
    logic                    out_last_q, out_last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [IDX_W-1:0] count_inc;
    logic [IDX_W-1:0] next_addr;
    logic             transfer;

    assign count_inc = count_q + IDX_W'(1);
    assign transfer  = out_valid_q && out_if.out_ready;

    // Outputs are registered, so the address of the sample presented after a
    // transfer is derived from the incremented count.
    bitrev_addr #(.IDX_W(IDX_W)) u_next_addr (
        .idx_in   (count_inc),
        .rev_en   (bitrev_q),
        .addr_out (next_addr)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        bitrev_d    = bitrev_q;
        snap_real_d = snap_real_q;
        snap_imag_d = snap_imag_q;
        out_valid_d = out_valid_q;
        out_real_d  = out_real_q;
        out_imag_d  = out_imag_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_STREAM;
                    count_d     = '0;
                    bitrev_d    = bitrev_en;
                    snap_real_d = in_real;
                    snap_imag_d = in_imag;
                    // Element 0 is index 0 in either order, so present it straight from the bank.
                    out_valid_d = 1'b1;
                    out_real_d  = in_real[0];
                    out_imag_d  = in_imag[0];
                    out_index_d = '0;
                    out_last_d  = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            ST_STREAM: begin
                if (transfer) begin
                    if (count_q == LAST_IDX) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        out_real_d  = '0;
                        out_imag_d  = '0;
                        out_index_d = '0;
                        out_last_d  = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        count_d     = count_inc;
                        out_real_d  = snap_real_q[next_addr];
                        out_imag_d  = snap_imag_q[next_addr];
                        out_index_d = next_addr;
                        out_last_d  = (count_inc == LAST_IDX);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            bitrev_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                snap_real_q[i] <= '0;
                snap_imag_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            bitrev_q    <= bitrev_d;
            snap_real_q <= snap_real_d;
            snap_imag_q <= snap_imag_d;
            out_valid_q <= out_valid_d;
            out_real_q  <= out_real_d;
            out_imag_q  <= out_imag_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_real  = out_real_q;
    assign out_if.out_imag  = out_imag_q;
    assign out_if.out_index = out_index_q;
    assign out_if.out_last  = out_last_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_register_bank_unloader.sv
// Scoreboard bench for register_bank_unloader: a driver pushes the expected
// frame order from a reference model, a monitor pops on every handshake.
module tb_register_bank_unloader;
    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int IDX_W = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   bitrev_en;
    logic [WIDTH*DEPTH-1:0] data_in_real;
    logic [WIDTH*DEPTH-1:0] data_in_imag;
    logic                   busy;
    logic                   done;

    register_bank_unloader_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) sif ();

    register_bank_unloader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bitrev_en    (bitrev_en),
        .data_in_real (data_in_real),
        .data_in_imag (data_in_imag),
        .out_if       (sif),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [WIDTH-1:0] re;
        logic signed [WIDTH-1:0] im;
        logic [IDX_W-1:0]        idx;
        logic                    last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   bank_re[DEPTH];
    int   bank_im[DEPTH];
    int   cycle = 0;
    int   ready_mode = 0;
    int   xfer_in_frame = 0;
    int   first_cycle = 0;
    int   last_cycle = 0;
    int   frame_gap = 0;
    bit   pending_done = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Reference order: reverse the IDX_W-bit binary digits of k arithmetically.
    function automatic int ref_rev(input int k);
        int r = 0;
        int v = k;
        for (int b = 0; b < IDX_W; b++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    task automatic pack_bank();
        for (int i = 0; i < DEPTH; i++) begin
            data_in_real[i*WIDTH +: WIDTH] = WIDTH'(bank_re[i]);
            data_in_imag[i*WIDTH +: WIDTH] = WIDTH'(bank_im[i]);
        end
    endtask

    task automatic random_bank();
        for (int i = 0; i < DEPTH; i++) begin
            bank_re[i] = $signed(16'($urandom));
            bank_im[i] = $signed(16'($urandom));
        end
    endtask

    task automatic push_frame(input bit rev);
        exp_t e;
        int   a;
        for (int k = 0; k < DEPTH; k++) begin
            a      = rev ? ref_rev(k) : k;
            e.re   = WIDTH'(bank_re[a]);
            e.im   = WIDTH'(bank_im[a]);
            e.idx  = IDX_W'(a);
            e.last = (k == DEPTH - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_frame(input bit rev);
        pack_bank();
        push_frame(rev);
        bitrev_en = rev;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        bitrev_en = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("first_valid_latency", sif.out_valid, 1);
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || pending_done) && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || pending_done) begin
            n_err++;
            $display("FAIL %s_timeout: remaining=%0d required=0", name, exp_q.size());
            exp_q.delete();
            pending_done = 1'b0;
        end
    endtask

    // Ready generator: held high, the 1,0,0,1 pattern, or random.
    initial begin
        int ph = 0;
        sif.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       sif.out_ready = 1'b1;
                1:       sif.out_ready = (ph % 4 == 0) || (ph % 4 == 3);
                default: sif.out_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
        end
    end

    // Monitor: handshake scoreboard, stall stability, done pulse and idle zeros.
    initial begin
        exp_t e;
        bit   stall_hold = 1'b0;
        logic signed [WIDTH-1:0] h_re, h_im;
        logic [IDX_W-1:0]        h_idx;
        logic                    h_last;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_hold = 1'b0;
                continue;
            end
            if (pending_done) begin
                check("done_pulse", done, 1);
                check("busy_in_done_cycle", busy, 0);
                pending_done = 1'b0;
            end else if (done) begin
                check("unexpected_done", done, 0);
            end
            if (stall_hold) begin
                check("stall_valid_held", sif.out_valid, 1);
                check("stall_data_held", {sif.out_real, sif.out_imag, sif.out_index, sif.out_last},
                      {h_re, h_im, h_idx, h_last});
            end
            if (sif.out_valid && sif.out_ready) begin
                stall_hold = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_transfer", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_index", sif.out_index, e.idx);
                    check("out_real", sif.out_real, e.re);
                    check("out_imag", sif.out_imag, e.im);
                    check("out_last", sif.out_last, e.last);
                    $display("xfer %0d: idx=%0d re=%0d im=%0d last=%0b", xfer_in_frame,
                             sif.out_index, sif.out_real, sif.out_imag, sif.out_last);
                    if (xfer_in_frame == 0) begin
                        frame_gap   = cycle - last_cycle;
                        first_cycle = cycle;
                    end
                    xfer_in_frame++;
                    if (e.last) begin
                        last_cycle    = cycle;
                        xfer_in_frame = 0;
                        pending_done  = 1'b1;
                    end
                end
            end else if (sif.out_valid) begin
                stall_hold = 1'b1;
                h_re   = sif.out_real;
                h_im   = sif.out_imag;
                h_idx  = sif.out_index;
                h_last = sif.out_last;
            end else begin
                stall_hold = 1'b0;
                check("idle_outputs_zero",
                      {sif.out_real, sif.out_imag, sif.out_index, sif.out_last}, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst          = 1'b1;
        start        = 1'b0;
        bitrev_en    = 1'b0;
        data_in_real = '0;
        data_in_imag = '0;
        repeat (2) @(negedge clk);
        check("reset_valid", sif.out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_data", {sif.out_real, sif.out_imag, sif.out_index, sif.out_last}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);

        // Natural order, ready held high: 16 back-to-back transfers
        for (int i = 0; i < DEPTH; i++) begin
            bank_re[i] = i * 3;
            bank_im[i] = -i;
        end
        ready_mode = 0;
        start_frame(1'b0);
        wait_drain("natural", 100);
        check("natural_throughput", last_cycle - first_cycle, DEPTH - 1);

        // Bit-reversed order, same data
        start_frame(1'b1);
        wait_drain("bitrev", 100);
        check("bitrev_throughput", last_cycle - first_cycle, DEPTH - 1);

        // Backpressure 1,0,0,1
        ready_mode = 1;
        start_frame(1'($urandom_range(0, 1)));
        wait_drain("backpressure", 200);

        // Snapshot isolation and mid-frame start
        ready_mode = 0;
        random_bank();
        start_frame(1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            data_in_real[i*WIDTH +: WIDTH] = 16'($urandom);
            data_in_imag[i*WIDTH +: WIDTH] = 16'($urandom);
        end
        repeat (4) @(negedge clk);
        bitrev_en = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain("snapshot", 100);
        repeat (3) @(negedge clk);
        check("no_restart_busy", busy, 0);

        // Reset mid-frame at transfer 5
        random_bank();
        start_frame(1'b1);
        k = 0;
        while (xfer_in_frame < 5 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("reach_transfer5", xfer_in_frame >= 5, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_valid", sif.out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_data", {sif.out_real, sif.out_imag, sif.out_index, sif.out_last, done}, 0);
        exp_q.delete();
        pending_done  = 1'b0;
        xfer_in_frame = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        random_bank();
        start_frame(1'b0);
        wait_drain("after_reset", 100);

        // Start in the done cycle with new data
        random_bank();
        start_frame(1'b1);
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done, 1);
        random_bank();
        start_frame(1'b0);
        wait_drain("back_to_back", 100);
        check("back_to_back_gap", frame_gap, 2);

        // Random frames with random backpressure
        for (int f = 0; f < 6; f++) begin
            ready_mode = (f % 2 == 0) ? 2 : 1;
            random_bank();
            start_frame(1'($urandom_range(0, 1)));
            wait_drain("random_frame", 300);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/register_bank_unloader.md
Name: register_bank_unloader

Overview:
Reads the flattened complex parallel output of a register bank and streams it out one complex sample per transfer over a valid/ready interface. It sits between the FFT stage register bank and downstream serial consumers such as the output FIFO or the DMA packer. A start pulse snapshots all DEPTH samples, so the bank is free to be rewritten immediately. The stream order is either natural or bit-reversed, selected per frame.

Parameters:
WIDTH, 16, bits per real/imag component (signed two's complement)
DEPTH, 16, samples per frame; power of two, >= 2
IDX_W, $clog2(DEPTH), local parameter, index width; not overridable

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  frame request; sampled only in IDLE
bitrev_en  input  1  1 = bit-reversed order; latched with start
data_in_real  input  WIDTH*DEPTH  flattened real samples; sample i at [(i+1)*WIDTH-1 -: WIDTH]
data_in_imag  input  WIDTH*DEPTH  flattened imaginary samples; same packing
out_valid  output  1  out_* holds a valid sample
out_ready  input  1  consumer accepts the sample
out_real  output  WIDTH  signed real sample
out_imag  output  WIDTH  signed imaginary sample
out_index  output  IDX_W  bank index of the presented sample (post-reorder)
out_last  output  1  presented sample is the final one of the frame
busy  output  1  frame in progress
done  output  1  one-cycle pulse after the last transfer

Behaviour:
- Reset (asynchronous, rst=1): state IDLE; counter 0; snapshot regs 0; out_valid, out_last, busy, done all 0; out_real, out_imag, out_index 0. A reset mid-frame aborts the frame: no done pulse, and the partial frame is discarded.
- FSM has two states, IDLE and STREAM.
- IDLE:
  - start=1 at edge N: capture all DEPTH real/imag samples into snapshot regs, latch bitrev_en, clear count to 0, go to STREAM.
  - From cycle N+1: busy=1, out_valid=1, element 0 presented.
- STREAM:
  - Transfer occurs when out_valid && out_ready at a rising edge.
  - On transfer with count < DEPTH-1: count increments.
  - On transfer with count = DEPTH-1: go to IDLE; in the next cycle done=1, busy=0, out_valid=0.
  - Without a transfer: count, out_real, out_imag, out_index and out_last hold stable (no glitching under backpressure).
  - start is ignored in STREAM. Changes to data_in_* are ignored after the snapshot.
- Addressing:
  - addr = latched_bitrev ? bit-reverse(count over IDX_W bits) : count.
  - out_real = snap_real[addr], out_imag = snap_imag[addr], out_index = addr.
  - out_last = (count == DEPTH-1) while out_valid=1.
- When out_valid=0: out_real, out_imag and out_index are driven to 0, and out_last=0.
- Throughput: DEPTH transfers in DEPTH cycles when out_ready is held at 1. Frame latency from start to the first valid sample is 1 cycle.
- done cycle: state is already IDLE, so a start in the same cycle as done is accepted. Back-to-back frames cost exactly 1 idle cycle (the done cycle) between the last and first transfers.
- No arithmetic is performed; samples pass bit-exact with sign preserved.
- out_ready may be asserted while out_valid=0; it has no effect.

Decomposition:
- Shared package fft_common_pkg holds:
  - the WIDTH/DEPTH defaults;
  - a flattened-bus slice helper (index i -> bit range);
  - the bit-reverse function bitrev(value, IDX_W), shared with the future bank loader and the FFT address generators.
- One natural sub-module: bitrev_addr (combinational, IDX_W-parameterised), reused by the FFT stage sequencer.
- Snapshot storage and the FSM stay in this module.

Test Plan:
1. Bank samples real = i*3, imag = -i; start with bitrev_en=0 and out_ready held 1 -> 16 transfers on consecutive cycles in order 0..15, out_last only on index 15, done pulse on the next cycle.
2. Same data with bitrev_en=1 -> out_index sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with matching sample values.
3. Toggle out_ready 1,0,0,1 pattern -> outputs held during stalls, no sample lost or duplicated, 16 transfers total.
4. Change data_in_* the cycle after start, and pulse start mid-frame -> streamed values equal the original snapshot, frame length unchanged, no restart.
5. Assert rst at transfer 5 -> all outputs 0 immediately, no done pulse; a new start afterwards streams a full frame from index 0.
6. Assert start in the done cycle with new data -> the second frame begins on the next cycle, busy high, element 0 of the new data presented.
